// File: rtl/psum_accum.sv
// -----------------------------------------------------------------------------
// psum_accum
//
// Accumulates a configurable number of registered partial sums from the int32
// adder stage into one group sum. It sits between the adder tree output and
// the output buffer/writeback. Valid/ready handshakes on both sides let
// writeback back-pressure stall the adder stream without losing data.
//
// Configuration macro:
//   PSUM_SAT_EN : when defined, each add is signed-saturating and a sticky
//                 per-group flag is reported on out_sat. When undefined, adds
//                 wrap modulo 2^DATA_W and out_sat is tied low.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   cfg_len   in   partial sums per group (0 treated as 1), sampled on the
//                  first beat of each group
//   in_valid  in   in_data holds a valid partial sum
//   in_data   in   partial sum from the adder stage
//   in_ready  out  block accepts in_data this cycle
//   out_valid out  out_data holds a completed group sum
//   out_data  out  accumulated group sum (driven from the acc register)
//   out_ready in   downstream accepts out_data
//   out_sat   out  group sum was clamped (PSUM_SAT_EN only, else 0)
//   busy      out  a group is in progress or held for output
// -----------------------------------------------------------------------------
module psum_accum #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_sat,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [DATA_W-1:0] ACC_ZERO = {DATA_W{1'b0}};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;

  logic [CNT_W-1:0]  new_len;    // cfg_len with 0 mapped to 1
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] add_sum;    // acc_q + in_data (wrapped or clamped)
  logic              start_grp;  // accepted beat opens a new group

`ifdef PSUM_SAT_EN
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic sat_q, sat_d;
  logic add_clamp;

  // Signed saturating add; result is {clamped, value}. Overflow is only
  // possible when both operands share a sign and the sum's sign differs.
  function automatic logic [DATA_W:0] sat_add(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] s;
    s = a + b;
    if ((a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1])) begin
      if (a[DATA_W-1]) begin
        sat_add = {1'b1, SAT_MIN};
      end else begin
        sat_add = {1'b1, SAT_MAX};
      end
    end else begin
      sat_add = {1'b0, s};
    end
  endfunction

  // Saturating adder feeding the accumulator.
  always_comb begin
    {add_clamp, add_sum} = sat_add(acc_q, in_data);
  end
`else
  // Wrapping adder feeding the accumulator.
  always_comb begin
    add_sum = acc_q + in_data;
  end
`endif

  // Group length and beat-counter helpers.
  always_comb begin
    if (cfg_len == CNT_ZERO) begin
      new_len = CNT_ONE;
    end else begin
      new_len = cfg_len;
    end
    cnt_inc = cnt_q + CNT_ONE;
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
`ifdef PSUM_SAT_EN
    sat_d     = sat_q;
`endif
    start_grp = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          start_grp = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
`ifdef PSUM_SAT_EN
          sat_d = sat_q | add_clamp;
`endif
          if (cnt_inc == len_q) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ACC;
          end
        end else begin
          state_d = S_ACC;
        end
      end
      S_DRAIN: begin
        // Input is only taken when the held sum leaves in the same cycle,
        // which lets a new group start with no bubble.
        in_ready  = out_ready;
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          if (in_valid) begin
            start_grp = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
        acc_d   = ACC_ZERO;
        cnt_d   = CNT_ZERO;
        len_d   = CNT_ZERO;
`ifdef PSUM_SAT_EN
        sat_d   = 1'b0;
`endif
      end
    endcase

    // First beat of a group: latch length, restart acc/cnt, clear sat flag.
    if (start_grp) begin
      len_d = new_len;
      acc_d = in_data;
      cnt_d = CNT_ONE;
`ifdef PSUM_SAT_EN
      sat_d = 1'b0;
`endif
      if (new_len == CNT_ONE) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_ACC;
      end
    end else begin
      len_d = len_d;
    end
  end

  // State, accumulator, counter and length registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= ACC_ZERO;
      cnt_q   <= CNT_ZERO;
      len_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

`ifdef PSUM_SAT_EN
  // Sticky per-group saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign out_sat = sat_q;
`else
  assign out_sat = 1'b0;
`endif

  // Output sum comes straight from the accumulator register.
  assign out_data = acc_q;

endmodule
